// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract unit: one full-adder cell stepped LSB-first over WIDTH cycles.
// Optional signed-overflow output enabled by defining SERIAL_ADDSUB_OVF_EN.

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_addsub_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDSUB_OVF_EN
  output logic             ovf,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic             load, step, last;
  logic [WIDTH-1:0] sa, sb;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             cell_sum, cell_cout;

  full_adder_cell u_fa (
    .a   (sa[0]),
    .b   (sb[0]),
    .cin (carry),
    .sum (cell_sum),
    .cout(cell_cout)
  );

  assign last = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: invert B at load and seed the carry with op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (load) begin
      sa    <= a;
      sb    <= op ? ~b : b;
      carry <= op;
      cnt   <= '0;
    end else if (step) begin
      sa     <= sa >> 1;
      sb     <= sb >> 1;
      carry  <= cell_cout;
      cnt    <= cnt + CNT_W'(1);
      result <= {cell_sum, result[WIDTH-1:1]};
      if (last) begin
        cout <= cell_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
        // carry still holds the carry into the MSB on the final step
        ovf  <= carry ^ cell_cout;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl at WIDTH=8; checks ovf too when
// SERIAL_ADDSUB_OVF_EN is defined.

module tb_serial_addsub_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout;
  logic [W-1:0] result;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic         ovf;
`endif

  int   total = 0;
  int   bad = 0;
  int   n_push = 0;
  int   n_done = 0;
  exp_t sb_q[$];

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADDSUB_OVF_EN
    .ovf   (ovf),
`endif
    .busy  (busy),
    .done  (done),
    .result(result),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t         m;
    logic [W-1:0] yy;
    logic [W:0]   s;
    yy    = o ? ~y : y;
    s     = {1'b0, x} + {1'b0, yy} + (W+1)'(o);
    m.res = s[W-1:0];
    m.co  = s[W];
    m.ov  = (x[W-1] == yy[W-1]) && (s[W-1] != x[W-1]);
    return m;
  endfunction

  // Scoreboard monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (busy && done) begin
      total++; bad++;
      $display("FAIL busy_done_overlap: got busy=1 done=1 want not both");
    end
    if (done) begin
      exp_t e;
      n_done++;
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got done with empty scoreboard want no done");
      end else begin
        e = sb_q.pop_front();
        if ({result, cout} !== {e.res, e.co}) begin
          bad++;
          $display("FAIL result: got result=%h cout=%b want result=%h cout=%b", result, cout, e.res, e.co);
        end
`ifdef SERIAL_ADDSUB_OVF_EN
        total++;
        if (ovf !== e.ov) begin
          bad++;
          $display("FAIL ovf: got %b want %b (result=%h)", ovf, e.ov, e.res);
        end
`endif
      end
    end
  end

  task automatic go(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
  endtask

  task automatic push(input exp_t e);
    sb_q.push_back(e);
    n_push++;
  endtask

  task automatic wait_done(output int nbusy, output bit ok);
    nbusy = 0;
    ok    = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) ok = 1'b1;
      else if (busy) nbusy++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, cout} !== 3'b000) begin
      bad++;
      $display("FAIL reset_ctrl: got busy=%b done=%b cout=%b want 0 0 0", busy, done, cout);
    end
    total++;
    if (result !== '0) begin
      bad++;
      $display("FAIL reset_result: got %h want 00", result);
    end
`ifdef SERIAL_ADDSUB_OVF_EN
    total++;
    if (ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_ovf: got %b want 0", ovf);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int nb;
    bit ok;
    go(1'b0, 8'h3C, 8'h21);
    push(exp_t'({8'h5D, 1'b0, 1'b0}));
    wait_done(nb, ok);
    total++;
    if (!ok || nb != 8) begin
      bad++;
      $display("FAIL basic_latency: got done=%b busy_cycles=%0d want done=1 busy_cycles=8", ok, nb);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse_width: got done=%b busy=%b want 0 0", done, busy);
    end
    total++;
    if (result !== 8'h5D || cout !== 1'b0) begin
      bad++;
      $display("FAIL result_hold: got %h/%b want 5d/0", result, cout);
    end
  endtask

  task automatic test_arith;
    logic [W-1:0] va[5] = '{8'hFF, 8'h05, 8'h07, 8'h7F, 8'h80};
    logic [W-1:0] vb[5] = '{8'h01, 8'h07, 8'h05, 8'h01, 8'h01};
    logic         vo[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_t         ve[5] = '{exp_t'({8'h00, 1'b1, 1'b0}), exp_t'({8'hFE, 1'b0, 1'b0}),
                            exp_t'({8'h02, 1'b1, 1'b0}), exp_t'({8'h80, 1'b0, 1'b1}),
                            exp_t'({8'h7F, 1'b1, 1'b1})};
    int nb;
    bit ok;
    for (int i = 0; i < 5; i++) begin
      go(vo[i], va[i], vb[i]);
      push(ve[i]);
      wait_done(nb, ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL arith_timeout: vector %0d got no done want done", i);
      end
    end
    for (int i = 0; i < 8; i++) begin
      logic         ro;
      logic [W-1:0] ra, rb;
      ro = 1'($urandom_range(0, 1));
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      go(ro, ra, rb);
      push(model(ro, ra, rb));
      wait_done(nb, ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL random_timeout: iter %0d got no done want done", i);
      end
    end
  endtask

  task automatic test_start_ignored;
    int dcyc;
    dcyc = -1;
    go(1'b0, 8'h12, 8'h34);
    push(exp_t'({8'h46, 1'b0, 1'b0}));
    for (int c = 1; c <= 40 && dcyc < 0; c++) begin
      @(negedge clk);
      start = (c == 3);
      if (c == 3) begin
        op = 1'b1; a = 8'hAA; b = 8'h55;
      end
      if (done) dcyc = c;
    end
    total++;
    if (dcyc != 9) begin
      bad++;
      $display("FAIL ignore_latency: got done at cycle %0d want 9", dcyc);
    end
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || result !== 8'h46) begin
      bad++;
      $display("FAIL ignore_no_launch: got busy=%b result=%h want 0/46", busy, result);
    end
  endtask

  task automatic test_back_to_back;
    int first, second;
    first  = -1;
    second = -1;
    go(1'b0, 8'h10, 8'h20);
    push(exp_t'({8'h30, 1'b0, 1'b0}));
    @(negedge clk);
    op = 1'b1; a = 8'h10; b = 8'h20;
    push(exp_t'({8'hF0, 1'b0, 1'b0}));
    for (int c = 1; c <= 60 && second < 0; c++) begin
      @(negedge clk);
      if (done) begin
        if (first < 0) first = c;
        else second = c;
      end else if (first >= 0 && busy) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    total++;
    if (first < 0 || second < 0 || second - first != 9) begin
      bad++;
      $display("FAIL back_to_back: got done at %0d and %0d want 9 apart", first, second);
    end
  endtask

  task automatic test_reset_mid_run;
    int nb;
    bit ok;
    bit saw_done;
    go(1'b0, 8'h11, 8'h22);
    push(exp_t'({8'h33, 1'b0, 1'b0}));
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    void'(sb_q.pop_back());
    n_push--;
    #1;
    total++;
    if ({busy, done, cout} !== 3'b000 || result !== '0) begin
      bad++;
      $display("FAIL mid_reset: got busy=%b done=%b cout=%b result=%h want 0 0 0 00", busy, done, cout, result);
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    total++;
    if (saw_done) begin
      bad++;
      $display("FAIL mid_reset_done: got done pulse want none");
    end
    go(1'b1, 8'h40, 8'h41);
    push(exp_t'({8'hFF, 1'b0, 1'b0}));
    wait_done(nb, ok);
    total++;
    if (!ok || nb != 8) begin
      bad++;
      $display("FAIL after_reset: got done=%b busy_cycles=%0d want 1/8", ok, nb);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arith();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    repeat (3) @(negedge clk);
    total++;
    if (sb_q.size() != 0 || n_done != n_push) begin
      bad++;
      $display("FAIL scoreboard_drain: got pending=%0d dones=%0d want pending=0 dones=%0d", sb_q.size(), n_done, n_push);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
